// File: rtl/irq_pending_capture.sv
// Interrupt front-end: edge capture into sticky pending bits, feeds an external
// 8:3 priority encoder and hands its winner out over req/ack. Option: IRQ_SYNC_EN.
module irq_pending_capture (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irq_in,
  input  logic [7:0] irq_en,
  output logic [7:0] pend_o,
  input  logic [2:0] code_i,
  output logic       irq_req,
  output logic [2:0] irq_id,
  input  logic       irq_ack,
  output logic [7:0] ovf_o
);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  state_t     state, state_nxt;
  logic [7:0] s, prev, pend, ovf, edg, clr, ovf_set;
  logic       id_ld;

`ifdef IRQ_SYNC_EN
  logic [7:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      s    <= '0;
    end else begin
      meta <= irq_in;
      s    <= meta;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s <= '0;
    else        s <= irq_in;
  end
`endif

  assign edg = s & ~prev;

  // Only the frozen index is cleared, and only on an ack taken in REQ.
  always_comb begin
    clr = '0;
    if (state == REQ && irq_ack) clr[irq_id] = 1'b1;
  end

  assign ovf_set = edg & pend & ~clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= '0;
      pend <= '0;
      ovf  <= '0;
    end else begin
      prev <= s;
      pend <= edg | (pend & ~clr);
      ovf  <= ovf_set | (ovf & ~clr);
    end
  end

  assign pend_o = pend & irq_en;
  assign ovf_o  = ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      irq_id <= 3'd0;
    end else begin
      state <= state_nxt;
      if (id_ld) irq_id <= code_i;
    end
  end

  // code_i is only trusted while something is forwarded to the encoder.
  always_comb begin
    state_nxt = state;
    id_ld     = 1'b0;
    unique case (state)
      IDLE: if (|pend_o) begin
        id_ld     = 1'b1;
        state_nxt = REQ;
      end
      REQ:  if (irq_ack) state_nxt = GAP;
      GAP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Decoded straight from the state flop so an async reset drops it at once.
  assign irq_req = (state == REQ);

endmodule

// File: tb/tb_irq_pending_capture.sv
// Scoreboard bench for irq_pending_capture with a behavioural 8:3 priority
// encoder closing the pend_o -> code_i loop.
module tb_irq_pending_capture;

`ifdef IRQ_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq_in, irq_en, pend_o, ovf_o;
  logic [2:0] code_i, irq_id;
  logic       irq_req, irq_ack;

  int checks = 0;
  int errors = 0;
  int q[$];
  int w, w2, w3;

  irq_pending_capture dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .irq_en(irq_en),
    .pend_o(pend_o), .code_i(code_i), .irq_req(irq_req), .irq_id(irq_id),
    .irq_ack(irq_ack), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  // Highest set bit wins.
  always_comb begin
    code_i = 3'd0;
    for (int i = 0; i < 8; i++) if (pend_o[i]) code_i = i[2:0];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_req(output int waits);
    waits = 0;
    while (!irq_req && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!irq_req) begin
      chk("req_timeout", 0, 1);
      waits = -1;
    end
  endtask

  task automatic pop_chk();
    int e;
    if (q.size() == 0) chk("sb_underflow", 1, 0);
    else begin
      e = q.pop_front();
      chk("irq_id", {29'd0, irq_id}, e);
    end
  endtask

  task automatic ack_pulse();
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    chk("req_drop", {31'd0, irq_req}, 0);
  endtask

  task automatic service(output int waits);
    wait_req(waits);
    pop_chk();
    ack_pulse();
  endtask

  task automatic quiet();
    irq_in = 8'h00;
    tick(4);
  endtask

  initial begin
    rst_n = 1'b0; irq_in = 8'hFF; irq_en = 8'hFF; irq_ack = 1'b0;
    tick(3);
    chk("rst_pend", {24'd0, pend_o}, 0);
    chk("rst_req",  {31'd0, irq_req}, 0);
    chk("rst_id",   {29'd0, irq_id}, 0);
    chk("rst_ovf",  {24'd0, ovf_o}, 0);

    // Lines held high through reset release: exactly one event each.
    rst_n = 1'b1;
    tick(LAT + 1);
    chk("rel_pend", {24'd0, pend_o}, 32'hFF);
    for (int i = 7; i >= 0; i--) q.push_back(i);
    for (int i = 0; i < 8; i++) service(w);
    tick(3);
    chk("rel_drain", {24'd0, pend_o}, 0);
    chk("rel_ovf",   {24'd0, ovf_o}, 0);

    // Single event on line 5, latency checks.
    quiet();
    irq_in = 8'h20;
    q.push_back(5);
    tick(LAT);
    chk("lat_early", {24'd0, pend_o}, 0);
    tick(1);
    chk("lat_pend", {24'd0, pend_o}, 32'h20);
    chk("lat_noreq", {31'd0, irq_req}, 0);
    service(w);
    chk("pend_to_req", w, 1);
    tick(3);
    chk("single_clr", {24'd0, pend_o}, 0);
    chk("single_idle", {31'd0, irq_req}, 0);

    // Three coincident edges, immediate acks -> 3 cycle spacing.
    quiet();
    irq_in = 8'h92;
    q.push_back(7); q.push_back(4); q.push_back(1);
    service(w);
    service(w2);
    service(w3);
    chk("prio_gap2", w2, 2);
    chk("prio_gap3", w3, 2);

    // Masked line accumulates but is not forwarded.
    quiet();
    irq_en = 8'hF7;
    irq_in = 8'h08;
    tick(LAT + 4);
    chk("mask_pend", {24'd0, pend_o}, 0);
    chk("mask_req",  {31'd0, irq_req}, 0);
    irq_en = 8'hFF;
    q.push_back(3);
    service(w);

    // New edge on line 2 landing on the same edge as its ack.
    quiet();
    irq_in = 8'h04;
    q.push_back(2); q.push_back(2);
    wait_req(w);
    pop_chk();
    irq_in = 8'h00;
    tick(3);
    irq_in = 8'h04;
    tick(LAT);
    ack_pulse();
    chk("coll_keep", {31'd0, pend_o[2]}, 1);
    chk("coll_ovf",  {24'd0, ovf_o}, 0);
    // Second edge while still pending -> sticky overflow.
    irq_in = 8'h00;
    tick(3);
    irq_in = 8'h04;
    tick(LAT + 2);
    chk("ovf_set", {24'd0, ovf_o}, 32'h04);
    service(w);
    chk("ovf_clr", {24'd0, ovf_o}, 0);

    // Asynchronous reset while a request is outstanding.
    quiet();
    irq_in = 8'h40;
    wait_req(w);
    chk("areq_id", {29'd0, irq_id}, 6);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req",  {31'd0, irq_req}, 0);
    chk("arst_pend", {24'd0, pend_o}, 0);
    chk("arst_id",   {29'd0, irq_id}, 0);
    irq_in = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    tick(4);
    chk("arst_idle", {31'd0, irq_req}, 0);
    irq_in = 8'h40;
    q.push_back(6);
    service(w);

    chk("sb_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_pending_capture.md
# irq_pending_capture

Interrupt front-end that sits directly upstream of the 8:3 priority encoder `encode`. It detects rising edges on eight asynchronous request lines and holds them as pending bits. The enabled pending vector drives the encoder. The block latches the encoder's 3-bit winner into a req/ack handshake and clears the serviced bit on acknowledge.

## Interface
Parameters:
- none; width is fixed at 8 lines / 3-bit index, matching `encode`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `irq_in`  in  8  raw request lines; a rising edge is one event.
- `irq_en`  in  8  per-line enable; 1 = line may be forwarded.
- `pend_o`  out  8  `pend & irq_en`; drives `encode.I`.
- `code_i`  in  3  from `encode.D`; only sampled when `|pend_o`.
- `irq_req`  out  1  request valid to the consumer.
- `irq_id`  out  3  serviced line index; stable while `irq_req`=1.
- `irq_ack`  in  1  consumer acknowledge; single-cycle pulse.
- `ovf_o`  out  8  sticky: an edge arrived on a line that was already pending.

## Operation
- **Reset:**
  - `pend`, `ovf_o`, the synchronizer flops and edge-history flops all go to 0.
  - `irq_req`=0, `irq_id`=3'b000, state=IDLE.
  - A line held high at reset release therefore produces exactly one event.
- **Edge detect:** `edge[i] = s[i] & ~prev[i]`, where `s` is the sampled line. `prev <= s` every cycle.
- **Pending update, per bit, every cycle:**
  - `pend[i] <= edge[i] | (pend[i] & ~clr[i])`.
  - `clr[i]` is asserted only for `i == irq_id` on an accepted ack.
  - If set and clear coincide, set wins, so the new event is kept.
- **Overflow:**
  - `ovf_o[i]` is set when `edge[i] & pend[i] & ~clr[i]`.
  - `ovf_o[i]` is cleared when `clr[i]` fires without a coincident overflow.
- **Masking:** `irq_en` gates only `pend_o`. Masked lines still accumulate pending state and overflow.
- **FSM states:** IDLE, REQ, GAP.
  - IDLE: if `|pend_o`, capture `code_i` into `irq_id`, set `irq_req`=1, go to REQ. Otherwise stay.
  - REQ: `irq_id` is frozen, and later edges or `irq_en` changes do not alter it or withdraw the request. On `irq_ack`=1: clear `pend[irq_id]`, set `irq_req`=0, go to GAP.
  - GAP: one cycle so `pend_o` and the encoder settle after the clear. Then go to IDLE.
- `irq_ack` is ignored in IDLE and GAP.
- `code_i` is never sampled when `pend_o`==0, so the encoder's Z output is never captured.

## Timing
- **Event to pending:** the rising level is first sampled at edge N. Without the sync option, `pend_o` is high after edge N+1; with it, after N+2. See Configuration.
- **Pending to request:** `irq_req` rises at the first edge in IDLE where `|pend_o`, i.e. one cycle after `pend_o`.
- **Ack to next request:**
  - Ack sampled at edge A: `irq_req` is low after A and the state is GAP.
  - At edge A+1 the state returns to IDLE.
  - Earliest next `irq_req` is after edge A+2.
  - Minimum service period is 3 cycles.
- **`irq_ack` held high:** handled as one accept, since REQ is left immediately.
- **Reset mid-operation:** asynchronous. Every output takes its reset value immediately and in-flight events are discarded.

## Configuration
- **`IRQ_SYNC_EN` defined:** `irq_in` passes through a 2-flop synchronizer before edge detect. Latency from first sampling edge to `pend_o` is 2 cycles.
- **`IRQ_SYNC_EN` undefined:** `irq_in` is registered once before edge detect, for inputs already in `clk`'s domain. Latency is 1 cycle.
- All other behaviour is identical in both builds.

## Test plan
- **Reset:** hold `rst_n`=0 with `irq_in`=8'hFF → `pend_o`=0, `irq_req`=0, `irq_id`=0, `ovf_o`=0. Release → all 8 bits become pending.
- **Single event:** `irq_in[5]` 0→1, `irq_en`=8'hFF.
  - `pend_o`=8'h20 after the stated latency; next cycle `irq_req`=1, `irq_id`=5.
  - Ack → `pend_o`=0 and `irq_req` stays 0.
- **Priority sequence:** edges on lines 1, 4 and 7 in the same cycle → serviced as `irq_id`=7, then 4, then 1. Requests are 3 cycles apart when ack is returned immediately.
- **Masking:** edge on line 3 with `irq_en`=8'hF7 → `pend_o`=0 and no request. Then set `irq_en`=8'hFF → request with `irq_id`=3.
- **Set/clear collision:** a new edge on line 2 in the same cycle as the ack of `irq_id`=2 → `pend[2]` stays 1 and a second request with `irq_id`=2 follows. Also check that a second edge while pending sets `ovf_o[2]`.
- **Async reset during REQ:** assert `rst_n`=0 mid-cycle → `irq_req` drops without waiting for `clk`, and the state is IDLE after release.
